multi_dataflow_cfg_master: RTL and testbench
============================================

MULTI_DATAFLOW_CFG_MASTER -- requirements
Module: multi_dataflow_cfg_master

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 10: width of the periph transaction ID.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0: accelerator periph base address.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: event watchdog limit, used only with the macro in REQ-027.
REQ-004 SHALL have ports clk_i (in, 1), the single clock, and rst_ni (in, 1), the asynchronous active-low reset.
REQ-005 SHALL have port clear_i (in, 1): synchronous soft clear.
REQ-006 SHALL have ports cfg_valid_i (in, 1), cfg_ready_o (out, 1), cfg_idx_i (in, 8), cfg_data_i (in, 32) and cfg_last_i (in, 1): a job-register stream where cfg_idx_i is the job-register index.
REQ-007 SHALL have ports periph_req_o (out, 1), periph_gnt_i (in, 1), periph_add_o (out, 32), periph_wen_o (out, 1; 1 means read), periph_be_o (out, 4), periph_data_o (out, 32) and periph_id_o (out, ID_WIDTH).
REQ-008 SHALL have ports periph_r_valid_i (in, 1), periph_r_data_i (in, 32) and periph_r_id_i (in, ID_WIDTH).
REQ-009 SHALL have port evt_i (in, 1): accelerator end-of-job event, one cycle wide.
REQ-010 SHALL have ports busy_o (out, 1), done_o (out, 1; one-cycle pulse), job_id_o (out, 8) and error_o (out, 1; sticky).

Function
REQ-011 SHALL implement FSM states IDLE, ACQ, ACQ_WAIT, CFG, TRIG, WAIT_EVT and DONE.
REQ-012 IDLE SHALL go to ACQ when cfg_valid_i=1; no stream beat is consumed in IDLE.
REQ-013 ACQ SHALL drive a read: req=1, wen=1, add=BASE_ADDR+OFS_ACQUIRE, be=4'hF; on gnt it SHALL go to ACQ_WAIT.
REQ-014 ACQ_WAIT on r_valid: if r_data[31]=1 (busy), it SHALL return to ACQ; otherwise it SHALL latch r_data[7:0] into job_id_o and go to CFG.
REQ-015 In CFG, cfg_ready_o SHALL equal periph_gnt_i gated by cfg_valid_i and req.
REQ-016 In CFG, each beat SHALL write add=BASE_ADDR+OFS_JOB_REGS+4*cfg_idx_i with data=cfg_data_i, wen=0 and be=4'hF.
REQ-017 A beat SHALL be consumed only on req&gnt; when the accepted beat has cfg_last_i=1, the FSM SHALL go to TRIG.
REQ-018 TRIG SHALL write 0 to BASE_ADDR+OFS_TRIGGER; on gnt it SHALL go to WAIT_EVT.
REQ-019 WAIT_EVT SHALL go to DONE on evt_i=1; evt_i SHALL be ignored in all other states.
REQ-020 DONE SHALL pulse done_o for one cycle and return to IDLE.
REQ-021 The request fields add, wen, be, data and id SHALL stay stable while req=1 and gnt=0.
REQ-022 req SHALL deassert in the cycle after gnt; at most one transaction SHALL be outstanding.
REQ-023 periph_id_o SHALL be constant '0; r_valid SHALL be ignored outside ACQ_WAIT.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 clear_i SHALL force IDLE within one cycle, drop req and clear error_o, with an in-flight request abandoned and cfg_ready_o=0 in the same cycle.

Reset
REQ-026 On rst_ni=0 the block SHALL enter IDLE, with req, cfg_ready, busy, done and error at 0, job_id_o=0 and all periph request fields at 0.

Configuration
REQ-027 With MULTI_DATAFLOW_CFG_TIMEOUT_EN defined, a counter SHALL increment each WAIT_EVT cycle; on reaching TIMEOUT_CYCLES it SHALL set error_o, write 1 to OFS_SOFT_CLEAR and return to IDLE without done_o.
REQ-028 With MULTI_DATAFLOW_CFG_TIMEOUT_EN undefined, WAIT_EVT SHALL wait indefinitely, error_o SHALL be tied to 0, and no counter logic SHALL be synthesized.

Structure
REQ-029 The shared package multi_dataflow_cfg_package SHALL hold OFS_TRIGGER=0x00, OFS_ACQUIRE=0x04, OFS_FINISHED=0x08, OFS_STATUS=0x0C, OFS_SOFT_CLEAR=0x14 and OFS_JOB_REGS=0x40, plus the FSM state enum.
REQ-030 The watchdog SHALL be a sub-module, multi_dataflow_cfg_watchdog (enable, clear, expired), instantiated only under the macro.

Verification
REQ-031 Nominal job: ACQUIRE returns 3, then 3 beats (idx 0,1,2; last on 2) with gnt always 1 -> writes to 0x40/0x44/0x48, then 0x00, job_id_o=3; evt_i after 10 cycles -> done_o pulse.
REQ-032 Busy acquire: the first two ACQUIRE reads return 0xFFFFFFFF, the third returns 0 -> exactly 3 reads, then the config writes.
REQ-033 Backpressure: gnt held low 5 cycles on beat 1 -> request fields stable, no beat lost, cfg_ready_o=0 until gnt.
REQ-034 Mid-job clear: clear_i asserted in CFG after 1 beat -> IDLE next cycle, req=0, busy_o=0; a later job runs normally.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=20): no evt_i -> error_o=1 at cycle 20, write to 0x14, no done_o. With the macro off, the bench SHALL check that the block stays in WAIT_EVT.

Source files
------------

// File: rtl/multi_dataflow_cfg_package.sv
// multi_dataflow_cfg_package: accelerator register offsets and the config-master FSM state type.
package multi_dataflow_cfg_package;
  localparam logic [31:0] OFS_TRIGGER    = 32'h00;
  localparam logic [31:0] OFS_ACQUIRE    = 32'h04;
  localparam logic [31:0] OFS_FINISHED   = 32'h08;
  localparam logic [31:0] OFS_STATUS     = 32'h0C;
  localparam logic [31:0] OFS_SOFT_CLEAR = 32'h14;
  localparam logic [31:0] OFS_JOB_REGS   = 32'h40;
  typedef enum logic [2:0] {IDLE, ACQ, ACQ_WAIT, CFG, TRIG, WAIT_EVT, DONE} state_e;
endpackage

// File: rtl/multi_dataflow_cfg_watchdog.sv
// multi_dataflow_cfg_watchdog: counts enabled cycles and flags expiry once LIMIT is reached.
module multi_dataflow_cfg_watchdog #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_cnt <= '0;
    else if (clear_i || !en_i) r_cnt <= '0;
    else if (!expired_o) r_cnt <= r_cnt + 1'b1;
  assign expired_o = r_cnt == W'(LIMIT);
endmodule

// File: rtl/multi_dataflow_cfg_master.sv
// multi_dataflow_cfg_master: acquires an accelerator job slot, streams job registers, triggers and waits for the end event.
// Optional event watchdog enabled by defining MULTI_DATAFLOW_CFG_TIMEOUT_EN.
module multi_dataflow_cfg_master
  import multi_dataflow_cfg_package::*;
#(
  parameter int unsigned ID_WIDTH       = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [7:0]          cfg_idx_i,
  input  logic [31:0]         cfg_data_i,
  input  logic                cfg_last_i,
  output logic                periph_req_o,
  input  logic                periph_gnt_i,
  output logic [31:0]         periph_add_o,
  output logic                periph_wen_o,
  output logic [3:0]          periph_be_o,
  output logic [31:0]         periph_data_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic                periph_r_valid_i,
  input  logic [31:0]         periph_r_data_i,
  input  logic [ID_WIDTH-1:0] periph_r_id_i,
  input  logic                evt_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [7:0]          job_id_o,
  output logic                error_o
);
  state_e r_state, w_next;
  logic [7:0] r_job_id;
  logic w_expired;
  logic w_unused;
`ifdef MULTI_DATAFLOW_CFG_TIMEOUT_EN
  logic r_error;
  multi_dataflow_cfg_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (r_state == WAIT_EVT),
    .clear_i  (clear_i),
    .expired_o(w_expired)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_error <= 1'b0;
    else if (clear_i) r_error <= 1'b0;
    else if (r_state == WAIT_EVT && w_expired && !evt_i) r_error <= 1'b1;
  assign error_o  = r_error;
  assign w_unused = ^{periph_r_data_i[30:8], periph_r_id_i};
`else
  assign w_expired = 1'b0;
  assign error_o   = 1'b0;
  assign w_unused  = ^{periph_r_data_i[30:8], periph_r_id_i, TIMEOUT_CYCLES, w_expired};
`endif
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_job_id <= '0;
    else if (!clear_i && r_state == ACQ_WAIT && periph_r_valid_i && !periph_r_data_i[31])
      r_job_id <= periph_r_data_i[7:0];
  always_comb begin
    w_next        = r_state;
    periph_req_o  = 1'b0;
    periph_wen_o  = 1'b0;
    periph_be_o   = 4'h0;
    periph_add_o  = '0;
    periph_data_o = '0;
    case (r_state)
      IDLE: w_next = cfg_valid_i ? ACQ : IDLE;
      ACQ: begin
        periph_req_o = 1'b1;
        periph_wen_o = 1'b1;
        periph_be_o  = 4'hF;
        periph_add_o = BASE_ADDR + OFS_ACQUIRE;
        w_next       = periph_gnt_i ? ACQ_WAIT : ACQ;
      end
      ACQ_WAIT: w_next = !periph_r_valid_i ? ACQ_WAIT : periph_r_data_i[31] ? ACQ : CFG;
      CFG: begin
        periph_req_o  = cfg_valid_i;
        periph_be_o   = {4{cfg_valid_i}};
        periph_add_o  = BASE_ADDR + OFS_JOB_REGS + {22'd0, cfg_idx_i, 2'b00};
        periph_data_o = cfg_data_i;
        w_next        = (cfg_valid_i && periph_gnt_i && cfg_last_i) ? TRIG : CFG;
      end
      TRIG: begin
        periph_req_o = 1'b1;
        periph_be_o  = 4'hF;
        periph_add_o = BASE_ADDR + OFS_TRIGGER;
        w_next       = periph_gnt_i ? WAIT_EVT : TRIG;
      end
      WAIT_EVT: begin
        // Expiry issues a soft-clear write and abandons the job without done.
        periph_req_o  = !evt_i && w_expired;
        periph_be_o   = {4{periph_req_o}};
        periph_add_o  = periph_req_o ? BASE_ADDR + OFS_SOFT_CLEAR : '0;
        periph_data_o = {31'd0, periph_req_o};
        w_next        = evt_i ? DONE : (periph_req_o && periph_gnt_i) ? IDLE : WAIT_EVT;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (clear_i) begin
      w_next       = IDLE;
      periph_req_o = 1'b0;
    end
  end
  assign cfg_ready_o = (r_state == CFG) && periph_req_o && periph_gnt_i;
  assign periph_id_o = '0;
  assign busy_o      = r_state != IDLE;
  assign done_o      = r_state == DONE;
  assign job_id_o    = r_job_id;
endmodule

// File: tb/tb_multi_dataflow_cfg_master.sv
// tb_multi_dataflow_cfg_master: randomized scoreboard bench for the config master (honours MULTI_DATAFLOW_CFG_TIMEOUT_EN).
module tb_multi_dataflow_cfg_master;
  localparam int          IDW  = 10;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          TO   = 20;
  typedef struct packed {
    logic [31:0]    add;
    logic           wen;
    logic [3:0]     be;
    logic [31:0]    data;
    logic [IDW-1:0] id;
  } txn_t;
  logic clk, rst_n, clear, cfg_valid, cfg_ready, cfg_last, req, gnt, wen, r_valid, evt, busy, done, error;
  logic [7:0] cfg_idx, job_id;
  logic [31:0] cfg_data, add, wdata, r_data;
  logic [3:0] be;
  logic [IDW-1:0] id, r_id;
  txn_t exp_q[$];
  logic [31:0] acq_q[$];
  logic [7:0] done_q[$];
  int n_vec, n_err, stall;
  bit rand_gnt, pend, prev_stall, prev_done;
  logic [31:0] pend_data;
  txn_t cur, prev_txn;
  multi_dataflow_cfg_master #(.ID_WIDTH(IDW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_idx_i(cfg_idx), .cfg_data_i(cfg_data), .cfg_last_i(cfg_last),
    .periph_req_o(req), .periph_gnt_i(gnt), .periph_add_o(add), .periph_wen_o(wen), .periph_be_o(be),
    .periph_data_o(wdata), .periph_id_o(id),
    .periph_r_valid_i(r_valid), .periph_r_data_i(r_data), .periph_r_id_i(r_id),
    .evt_i(evt), .busy_o(busy), .done_o(done), .job_id_o(job_id), .error_o(error)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic txn_t mk(logic [31:0] a, logic w, logic [31:0] d);
    return '{add: a, wen: w, be: 4'hF, data: d, id: '0};
  endfunction
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  // Monitor: scoreboard of accepted transactions, stall stability and done pulses.
  always @(negedge clk) begin
    cur = '{add: add, wen: wen, be: be, data: wdata, id: id};
    pend = 0;
    if (rst_n) begin
      if (req && gnt) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_txn: got %0h expected none", cur);
        end else chk("txn", cur, exp_q.pop_front());
        if (wen) begin
          pend = 1;
          pend_data = acq_q.size() > 0 ? acq_q.pop_front() : 32'h0;
        end
      end
      if (req && !gnt) chk("ready_while_stalled", cfg_ready, 0);
      if (prev_stall && req) chk("stable_fields", cur, prev_txn);
      if (done) begin
        if (done_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got job %0h expected no done", job_id);
        end else chk("done_job_id", job_id, done_q.pop_front());
        if (prev_done) chk("done_one_cycle", 0, 1);
      end
    end
    prev_stall = req && !gnt;
    prev_txn = cur;
    prev_done = done;
  end
  // Peripheral: read data one cycle after a granted read, plus stray r_valid noise.
  always @(posedge clk) begin
    #1;
    if (pend) begin
      r_valid = 1; r_data = pend_data;
    end else begin
      r_valid = ($urandom % 8) == 0; r_data = $urandom;
    end
    r_id = IDW'($urandom);
  end
  always @(posedge clk) begin
    #2;
    if (stall > 0) begin
      gnt = 0; stall--;
    end else gnt = rand_gnt ? (($urandom % 4) != 0) : 1'b1;
  end
  task automatic run_job(int nbusy, int nbeats, int stall_beat, bit do_clear, int evt_dly,
                         bit to_test, bit seq, logic [31:0] ok_resp);
    int keep;
    logic [7:0] bi[16];
    logic [31:0] bd[16];
    bit got;
    keep = 0;
    for (int i = 0; i <= nbusy; i++) begin
      exp_q.push_back(mk(BASE + 32'h04, 1, 0));
      acq_q.push_back(i < nbusy ? 32'hFFFF_FFFF : ok_resp);
    end
    for (int i = 0; i < nbeats; i++) begin
      bi[i] = seq ? 8'(i) : 8'($urandom);
      bd[i] = $urandom;
      if (!do_clear || i == 0) exp_q.push_back(mk(BASE + 32'h40 + 32'(bi[i]) * 4, 0, bd[i]));
    end
    if (!do_clear) exp_q.push_back(mk(BASE, 0, 0));
`ifdef MULTI_DATAFLOW_CFG_TIMEOUT_EN
    if (to_test) begin
      exp_q.push_back(mk(BASE + 32'h14, 0, 1));
      keep = 1;
    end
`endif
    @(posedge clk); #1;
    for (int i = 0; i < nbeats; i++) begin
      if (rand_gnt) begin
        cfg_valid = 0;
        repeat ($urandom % 3) begin @(posedge clk); #1; end
      end
      cfg_valid = 1; cfg_idx = bi[i]; cfg_data = bd[i]; cfg_last = (i == nbeats - 1);
      if (i == stall_beat) stall = 5;
      got = 0;
      for (int k = 0; k < 300 && !got; k++) begin
        @(negedge clk);
        got = cfg_ready;
      end
      chk("beat_accepted", got, 1);
      @(posedge clk); #1;
      if (do_clear) begin
        clear = 1; cfg_valid = 0;
        @(negedge clk);
        chk("clear_req", req, 0);
        chk("clear_ready", cfg_ready, 0);
        @(posedge clk); #1;
        clear = 0;
        @(negedge clk);
        chk("clear_busy", busy, 0);
        chk("clear_idle_req", req, 0);
        chk("clear_drain", exp_q.size(), 0);
        return;
      end
    end
    cfg_valid = 0;
    for (int k = 0; k < 300 && exp_q.size() > keep; k++) tick();
    chk("cfg_drain", exp_q.size(), keep);
    chk("job_id", job_id, ok_resp[7:0]);
    chk("busy_wait_evt", busy, 1);
    if (to_test) begin
`ifdef MULTI_DATAFLOW_CFG_TIMEOUT_EN
      for (int k = 0; k < TO + 20 && !error; k++) tick();
      chk("timeout_error", error, 1);
      for (int k = 0; k < 50 && (exp_q.size() > 0 || busy); k++) tick();
      chk("softclear_drain", exp_q.size(), 0);
      chk("timeout_idle", busy, 0);
      chk("error_sticky", error, 1);
      @(posedge clk); #1 clear = 1;
      @(posedge clk); #1 clear = 0;
      @(negedge clk);
      chk("error_cleared", error, 0);
      return;
`else
      repeat (40) @(negedge clk);
      chk("no_timeout_busy", busy, 1);
      chk("no_timeout_req", req, 0);
      chk("no_timeout_error", error, 0);
`endif
    end
    repeat (evt_dly) @(posedge clk);
    #1 evt = 1;
    done_q.push_back(ok_resp[7:0]);
    @(posedge clk); #1 evt = 0;
    for (int k = 0; k < 10 && done_q.size() > 0; k++) tick();
    chk("done_seen", done_q.size(), 0);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
  endtask
  initial begin
    rst_n = 0; clear = 0; cfg_valid = 0; cfg_idx = 0; cfg_data = 0; cfg_last = 0;
    gnt = 0; r_valid = 0; r_data = 0; r_id = 0; evt = 0; stall = 0; rand_gnt = 0;
    n_vec = 0; n_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_job_id", job_id, 0);
    chk("rst_fields", {add, wen, be, wdata, id}, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1 evt = 1;
    @(posedge clk); #1 evt = 0;
    repeat (3) @(negedge clk);
    chk("evt_ignored_idle", busy, 0);
    run_job(0, 3, -1, 0, 10, 0, 1, 32'h3);
    run_job(2, 3, -1, 0, 4, 0, 1, 32'h0);
    run_job(0, 3, 1, 0, 3, 0, 0, $urandom & 32'h7FFF_FFFF);
    run_job(1, 3, -1, 1, 0, 0, 0, $urandom & 32'h7FFF_FFFF);
    run_job(0, 2, -1, 0, 5, 0, 0, $urandom & 32'h7FFF_FFFF);
    run_job(0, 2, -1, 0, 2, 1, 0, $urandom & 32'h7FFF_FFFF);
    rand_gnt = 1;
    for (int j = 0; j < 10; j++) begin
      int nb;
      nb = 1 + $urandom % 5;
      run_job($urandom % 3, nb, ($urandom % 2) ? int'($urandom % nb) : -1, ($urandom % 5) == 0,
              1 + $urandom % 15, 0, 0, $urandom & 32'h7FFF_FFFF);
    end
    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
